// File: rtl/iic_pkg.sv
// Shared types for the I2C EEPROM master: FSM encoding and command codes.
// The TWR_WAIT state exists only when IIC_TWR_WAIT_EN is defined.
package iic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_SEND_BYTE,
        ST_GET_ACK,
        ST_RSTART,
        ST_RECV_BYTE,
        ST_SEND_NACK,
        ST_STOP,
`ifdef IIC_TWR_WAIT_EN
        ST_TWR_WAIT,
`endif
        ST_DONE,
        ST_ARM
    } state_e;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;

endpackage

// File: rtl/iic_bit_tick.sv
// SCL phase strobe generator: one counter per SCL period, four strobes
// (low-mid, rise, high-mid, fall); held at zero while disabled.
module iic_bit_tick #(
    parameter int unsigned CLK_DIV = 500
) (
    input  logic sysclk,
    input  logic rst,
    input  logic en,
    output logic tick_lo,
    output logic tick_rise,
    output logic tick_hi,
    output logic tick_fall
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LO_P   = CW'(CLK_DIV / 4);
    localparam logic [CW-1:0] RISE_P = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] HI_P   = CW'((CLK_DIV * 3) / 4);
    localparam logic [CW-1:0] LAST_P = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next phase count: wrap at period end, restart from 0 when idle
    always_comb begin
        cnt_d = '0;
        if (en && cnt_q != LAST_P) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // phase counter register
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_lo   = en && (cnt_q == LO_P);
    assign tick_rise = en && (cnt_q == RISE_P);
    assign tick_hi   = en && (cnt_q == HI_P);
    assign tick_fall = en && (cnt_q == LAST_P);

endmodule

// File: rtl/iic_eeprom_module.sv
// I2C master for a single-byte EEPROM write / random read.
// Optional macro IIC_TWR_WAIT_EN adds a post-write TWR_CYC wait.
module iic_eeprom_module
    import iic_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 500,
    parameter logic [6:0]  DEV_ADDR = 7'b1010000,
    parameter int unsigned TWR_CYC  = 250000
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [1:0] start_sig,
    input  logic [7:0] addr_sig,
    input  logic [7:0] wrdata,
    output logic       done_sig,
    output logic [7:0] rddata,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    state_e     state_q, state_d;
    logic [1:0] cmd_q, cmd_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic       abort_q, abort_d;
    logic       scl_q, scl_d;
    logic       sda_oe_q, sda_oe_d;
    logic       done_q, done_d;
    logic [7:0] rddata_q, rddata_d;
    logic       ack_err_q, ack_err_d;
`ifdef IIC_TWR_WAIT_EN
    localparam int TW_W = $clog2(TWR_CYC + 1);
    logic [TW_W-1:0] twr_cnt_q, twr_cnt_d;
`endif

    logic sda_in;
    logic tick_en;
    logic tick_lo, tick_rise, tick_hi, tick_fall;

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in   = sda;
    assign scl      = scl_q;
    assign done_sig = done_q;
    assign rddata   = rddata_q;
    assign ack_err  = ack_err_q;
    assign tick_en  = !(state_q inside {ST_IDLE, ST_ARM, ST_DONE});

    iic_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .sysclk    (sysclk),
        .rst       (rst),
        .en        (tick_en),
        .tick_lo   (tick_lo),
        .tick_rise (tick_rise),
        .tick_hi   (tick_hi),
        .tick_fall (tick_fall)
    );

    // transfer sequencing: next state, bus levels and result registers
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        abort_d    = abort_q;
        scl_d      = scl_q;
        sda_oe_d   = sda_oe_q;
        done_d     = 1'b0;
        rddata_d   = rddata_q;
        ack_err_d  = ack_err_q;
`ifdef IIC_TWR_WAIT_EN
        twr_cnt_d  = twr_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_sig == CMD_WR || start_sig == CMD_RD) begin
                    cmd_d      = start_sig;
                    addr_d     = addr_sig;
                    data_d     = wrdata;
                    sh_d       = {DEV_ADDR, 1'b0};
                    bit_cnt_d  = 3'd0;
                    byte_idx_d = 2'd0;
                    abort_d    = 1'b0;
                    state_d    = ST_START;
                end
            end
            // SDA released in low half, pulled low while SCL is high
            ST_START, ST_RSTART: begin
                if (tick_lo)   sda_oe_d = 1'b0;
                if (tick_rise) scl_d    = 1'b1;
                if (tick_hi)   sda_oe_d = 1'b1;
                if (tick_fall) begin
                    scl_d   = 1'b0;
                    state_d = ST_SEND_BYTE;
                end
            end
            ST_SEND_BYTE: begin
                if (tick_lo)   sda_oe_d = ~sh_q[7];
                if (tick_rise) scl_d    = 1'b1;
                if (tick_fall) begin
                    scl_d     = 1'b0;
                    sh_d      = {sh_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_GET_ACK;
                end
            end
            ST_GET_ACK: begin
                if (tick_lo)            sda_oe_d = 1'b0;
                if (tick_rise)          scl_d    = 1'b1;
                if (tick_hi && sda_in)  abort_d  = 1'b1;
                if (tick_fall) begin
                    scl_d      = 1'b0;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (abort_q) begin
                        state_d = ST_STOP;
                    end else begin
                        case (byte_idx_q)
                            2'd0: begin
                                sh_d    = addr_q;
                                state_d = ST_SEND_BYTE;
                            end
                            2'd1: begin
                                if (cmd_q == CMD_RD) begin
                                    sh_d       = {DEV_ADDR, 1'b1};
                                    byte_idx_d = 2'd3;
                                    state_d    = ST_RSTART;
                                end else begin
                                    sh_d    = data_q;
                                    state_d = ST_SEND_BYTE;
                                end
                            end
                            2'd2:    state_d = ST_STOP;
                            default: state_d = ST_RECV_BYTE;
                        endcase
                    end
                end
            end
            ST_RECV_BYTE: begin
                if (tick_lo)   sda_oe_d = 1'b0;
                if (tick_rise) scl_d    = 1'b1;
                if (tick_hi)   sh_d     = {sh_q[6:0], sda_in};
                if (tick_fall) begin
                    scl_d     = 1'b0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_SEND_NACK;
                end
            end
            ST_SEND_NACK: begin
                if (tick_lo)   sda_oe_d = 1'b0;
                if (tick_rise) scl_d    = 1'b1;
                if (tick_fall) begin
                    scl_d   = 1'b0;
                    state_d = ST_STOP;
                end
            end
            // SDA held low in low half, released while SCL is high
            ST_STOP: begin
                if (tick_lo)   sda_oe_d = 1'b1;
                if (tick_rise) scl_d    = 1'b1;
                if (tick_hi)   sda_oe_d = 1'b0;
                if (tick_fall) begin
                    state_d = ST_DONE;
`ifdef IIC_TWR_WAIT_EN
                    if (cmd_q == CMD_WR && !abort_q) state_d = ST_TWR_WAIT;
`endif
                end
            end
`ifdef IIC_TWR_WAIT_EN
            ST_TWR_WAIT: begin
                twr_cnt_d = twr_cnt_q + 1'b1;
                if (twr_cnt_q == TW_W'(TWR_CYC - 1)) begin
                    twr_cnt_d = '0;
                    state_d   = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done_d    = 1'b1;
                ack_err_d = abort_q;
                if (cmd_q == CMD_RD && !abort_q) rddata_d = sh_q;
                state_d   = ST_ARM;
            end
            ST_ARM: begin
                if (start_sig == CMD_NONE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_NONE;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            sh_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            abort_q    <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            rddata_q   <= 8'h00;
            ack_err_q  <= 1'b0;
`ifdef IIC_TWR_WAIT_EN
            twr_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            abort_q    <= abort_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            done_q     <= done_d;
            rddata_q   <= rddata_d;
            ack_err_q  <= ack_err_d;
`ifdef IIC_TWR_WAIT_EN
            twr_cnt_q  <= twr_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_iic_eeprom_module.sv
// Directed bench for iic_eeprom_module with a behavioural EEPROM slave.
// Honours IIC_TWR_WAIT_EN for the STOP-to-done gap expectation.
module tb_iic_eeprom_module;
    import iic_pkg::*;

    localparam int CLK_DIV = 8;
    localparam int TWR_CYC = 20;
`ifdef IIC_TWR_WAIT_EN
    localparam int WR_GAP = 2 + TWR_CYC;
`else
    localparam int WR_GAP = 2;
`endif
    localparam int RD_GAP = 2;

    logic       sysclk = 1'b0;
    logic       rst;
    logic [1:0] start_sig;
    logic [7:0] addr_sig;
    logic [7:0] wrdata;
    logic       done_sig;
    logic [7:0] rddata;
    logic       ack_err;
    logic       scl;
    wire        sda;

    logic s_oe = 1'b0;
    assign sda = s_oe ? 1'b0 : 1'bz;
    pullup (sda);

    iic_eeprom_module #(
        .CLK_DIV  (CLK_DIV),
        .DEV_ADDR (7'b1010000),
        .TWR_CYC  (TWR_CYC)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .start_sig (start_sig),
        .addr_sig  (addr_sig),
        .wrdata    (wrdata),
        .done_sig  (done_sig),
        .rddata    (rddata),
        .ack_err   (ack_err),
        .scl       (scl),
        .sda       (sda)
    );

    always #5 sysclk = ~sysclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;

    // bus log: 0x100 START, 0x200 STOP, 0x30x master ack bit, else byte
    logic [15:0] log_q[$];
    logic [15:0] exp_q[$];

    logic       nack_dev = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    int         mode = 0;
    int         bitn = 0;
    int         bytes_in = 0;
    logic       txmode = 1'b0;
    logic [7:0] sh = 8'h00;

    always @(posedge sysclk) cyc <= cyc + 1;

    // EEPROM slave model and done-pulse monitor
    always @(negedge sysclk) begin
        logic b;
        b = (sda !== 1'b0);
        if (done_sig) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (p_scl && scl && p_sda && !b) begin
            log_q.push_back(16'h100);
            mode = 0; bitn = 0; bytes_in = 0; txmode = 1'b0; s_oe = 1'b0;
        end else if (p_scl && scl && !p_sda && b) begin
            log_q.push_back(16'h200);
            stop_cyc = cyc;
            mode = 0; bitn = 0; s_oe = 1'b0;
        end else if (!p_scl && scl) begin
            case (mode)
                0: begin sh = {sh[6:0], b}; bitn = bitn + 1; end
                2: bitn = bitn + 1;
                3: log_q.push_back(16'h300 | {15'd0, b});
                default: ;
            endcase
        end else if (p_scl && !scl) begin
            case (mode)
                0: if (bitn == 8) begin
                    log_q.push_back({8'h00, sh});
                    if (bytes_in == 0) txmode = sh[0];
                    s_oe = !(bytes_in == 0 && nack_dev);
                    bytes_in = bytes_in + 1;
                    mode = 1;
                end
                1: if (txmode) begin
                    mode = 2; bitn = 0; s_oe = !tx_byte[7];
                end else begin
                    mode = 0; bitn = 0; s_oe = 1'b0;
                end
                2: if (bitn == 8) begin
                    s_oe = 1'b0; mode = 3;
                end else begin
                    s_oe = !tx_byte[7-bitn];
                end
                default: begin s_oe = 1'b0; mode = 0; bitn = 0; end
            endcase
        end
        p_scl = scl;
        p_sda = b;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check(tag, (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF,
                  32'(exp_q[i]));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done_sig && k < 4000) begin
            @(posedge sysclk); #1;
            k++;
        end
        if (!done_sig) check("done_timeout", 32'(done_sig), 32'd1);
    endtask

    // issue a command, scramble inputs after latch, release after done
    task automatic run_cmd(input logic [1:0] c, input logic [7:0] a,
                           input logic [7:0] d);
        done_cnt = 0;
        start_sig = c; addr_sig = a; wrdata = d;
        repeat (3) @(posedge sysclk);
        #1;
        addr_sig = ~a; wrdata = ~d;
        wait_done();
        start_sig = CMD_NONE;
        repeat (4) @(posedge sysclk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b1; start_sig = CMD_NONE; addr_sig = 8'h00; wrdata = 8'h00;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_done", 32'(done_sig), 32'd0);
        check("rst_rddata", 32'(rddata), 32'h00);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;

        exp_q = '{16'h100, 16'h0A0, 16'h000, 16'h0A7, 16'h200};
        run_cmd(CMD_WR, 8'h00, 8'hA7);
        check("wr_ack_err", 32'(ack_err), 32'd0);
        check("wr_done_cnt", 32'(done_cnt), 32'd1);
        check("wr_gap", 32'(done_cyc - stop_cyc), 32'(WR_GAP));
        check_log("wr_bus");

        tx_byte = 8'hA7;
        exp_q = '{16'h100, 16'h0A0, 16'h000, 16'h100, 16'h0A1,
                  16'h301, 16'h200};
        run_cmd(CMD_RD, 8'h00, 8'h00);
        check("rd_rddata", 32'(rddata), 32'hA7);
        check("rd_ack_err", 32'(ack_err), 32'd0);
        check("rd_done_cnt", 32'(done_cnt), 32'd1);
        check("rd_gap", 32'(done_cyc - stop_cyc), 32'(RD_GAP));
        check_log("rd_bus");

        tx_byte = 8'h3C;
        exp_q = '{16'h100, 16'h0A0, 16'h05A, 16'h100, 16'h0A1,
                  16'h301, 16'h200};
        run_cmd(CMD_RD, 8'h5A, 8'hFF);
        check("rd2_rddata", 32'(rddata), 32'h3C);
        check_log("rd2_bus");

        nack_dev = 1'b1;
        exp_q = '{16'h100, 16'h0A0, 16'h200};
        run_cmd(CMD_WR, 8'h10, 8'h55);
        check("nack_ack_err", 32'(ack_err), 32'd1);
        check("nack_rddata", 32'(rddata), 32'h3C);
        check("nack_done_cnt", 32'(done_cnt), 32'd1);
        check("nack_gap", 32'(done_cyc - stop_cyc), 32'(RD_GAP));
        check_log("nack_bus");

        tx_byte = 8'hC3;
        exp_q = '{16'h100, 16'h0A0, 16'h200};
        run_cmd(CMD_RD, 8'h20, 8'h00);
        check("nackrd_ack_err", 32'(ack_err), 32'd1);
        check("nackrd_rddata", 32'(rddata), 32'h3C);
        check_log("nackrd_bus");
        nack_dev = 1'b0;

        done_cnt = 0;
        start_sig = CMD_WR; addr_sig = 8'h22; wrdata = 8'h33;
        wait_done();
        @(posedge sysclk); #1;
        exp_q = '{16'h100, 16'h0A0, 16'h022, 16'h033, 16'h200};
        check_log("held_wr_bus");
        check("held_ack_err", 32'(ack_err), 32'd0);
        done_cnt = 0;
        repeat (100) @(posedge sysclk);
        #1;
        check("held_done_cnt", 32'(done_cnt), 32'd0);
        check("held_bus_len", 32'(log_q.size()), 32'd0);
        start_sig = CMD_NONE;
        @(posedge sysclk); #1;
        tx_byte = 8'h5E;
        exp_q = '{16'h100, 16'h0A0, 16'h022, 16'h100, 16'h0A1,
                  16'h301, 16'h200};
        run_cmd(CMD_RD, 8'h22, 8'h00);
        check("rearm_rddata", 32'(rddata), 32'h5E);
        check_log("rearm_bus");

        done_cnt = 0;
        start_sig = CMD_WR; addr_sig = 8'h5C; wrdata = 8'h11;
        k = 0;
        while (!(bytes_in == 1 && mode == 0 && bitn == 3) && k < 2000) begin
            @(posedge sysclk); #1;
            k++;
        end
        check("mid_reach", 32'(bitn), 32'd3);
        rst = 1'b1;
        start_sig = CMD_NONE;
        #1;
        check("mid_scl", 32'(scl), 32'd1);
        check("mid_sda", 32'(sda), 32'd1);
        check("mid_done", 32'(done_sig), 32'd0);
        repeat (3) @(posedge sysclk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge sysclk);
        #1;
        check("mid_done_cnt", 32'(done_cnt), 32'd0);
        log_q.delete();
        exp_q = '{16'h100, 16'h0A0, 16'h05C, 16'h011, 16'h200};
        run_cmd(CMD_WR, 8'h5C, 8'h11);
        check("post_rst_ack_err", 32'(ack_err), 32'd0);
        check("post_rst_done_cnt", 32'(done_cnt), 32'd1);
        check("post_rst_gap", 32'(done_cyc - stop_cyc), 32'(WR_GAP));
        check_log("post_rst_bus");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
